// File: rtl/arb_mux_nto1_pkg.sv
// Shared definitions for the N-to-1 registered selector: mode encodings and a
// constant-foldable clog2 used to size select/id fields.
package arb_mux_nto1_pkg;

   localparam int unsigned MODE_FIXED = 0;
   localparam int unsigned MODE_RR    = 1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/arb_mux_nto1_rr_arbiter.sv
// Round-robin arbiter: owns the priority pointer and the wrapping search that
// starts at the pointer; the pointer moves past the winner only on a transfer.
module rr_arbiter
   import arb_mux_nto1_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant_oh,
   output logic [SEL_W-1:0] grant_id
);

   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] idx_c;
   logic             found_c;
   int unsigned      idx_full_c;

   // First requester at or after ptr_q, wrapping modulo N.
   always_comb begin
      grant_oh   = '0;
      grant_id   = '0;
      found_c    = 1'b0;
      idx_full_c = 0;
      idx_c      = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx_full_c = 32'(ptr_q) + k;
         if (idx_full_c >= N) begin
            idx_full_c = idx_full_c - N;
         end
         idx_c = SEL_W'(idx_full_c);
         if (!found_c && req[idx_c]) begin
            found_c         = 1'b1;
            grant_oh[idx_c] = 1'b1;
            grant_id        = idx_c;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = (grant_id == SEL_W'(N - 1)) ? '0 : grant_id + SEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/arb_mux_nto1.sv
// N-channel registered selector with valid/ready handshakes. Fixed mode picks
// the channel named by sel; RR mode arbitrates round-robin among requesters.
module arb_mux_nto1
   import arb_mux_nto1_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned N       = 4,
   parameter int unsigned RR_MODE = MODE_FIXED,
   parameter int unsigned SEL_W   = clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   input  logic [SEL_W-1:0]   sel,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_id,
   input  logic               out_ready
);

   logic               can_load_c;
   logic [N-1:0]       grant_oh_c;
   logic [SEL_W-1:0]   grant_id_c;
   logic               xfer_c;
   logic [WIDTH-1:0]   sel_data_c;

   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_data_q,  out_data_d;
   logic [SEL_W-1:0]   out_id_q,    out_id_d;

   // Gating with rst_n keeps in_ready low while reset is held.
   assign can_load_c = rst_n & (~out_valid_q | out_ready);

   generate
      if (RR_MODE == MODE_RR) begin : g_rr
         logic unused_sel;
         assign unused_sel = ^sel;

         rr_arbiter #(
            .N     (N),
            .SEL_W (SEL_W)
         ) u_arb (
            .clk      (clk),
            .rst_n    (rst_n),
            .req      (in_valid),
            .advance  (xfer_c),
            .grant_oh (grant_oh_c),
            .grant_id (grant_id_c)
         );
      end else begin : g_fixed
         // Out-of-range sel matches no channel, so it yields no grant.
         always_comb begin
            grant_oh_c = '0;
            for (int unsigned i = 0; i < N; i++) begin
               if ((32'(sel) == i) && in_valid[i]) begin
                  grant_oh_c[i] = 1'b1;
               end
            end
         end
         assign grant_id_c = sel;
      end
   endgenerate

   assign in_ready = grant_oh_c & {N{can_load_c}};
   assign xfer_c   = |(in_valid & in_ready);

   always_comb begin
      sel_data_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_oh_c[i]) begin
            sel_data_c = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Load wins over drain so back-to-back transfers keep out_valid high.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      if (xfer_c) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data_c;
         out_id_d    = grant_id_c;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;

endmodule

// File: tb/tb_arb_mux_nto1.sv
// Directed bench: fixed-select N=4, round-robin N=4 and fixed-select N=3
// instances share clock and reset.
module tb_arb_mux_nto1;
   import arb_mux_nto1_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  f_valid, f_iready;
   logic [63:0] f_data;
   logic [1:0]  f_sel, f_oid;
   logic        f_oready, f_ov;
   logic [15:0] f_od;

   logic [3:0]  r_valid, r_iready;
   logic [63:0] r_data;
   logic [1:0]  r_sel, r_oid;
   logic        r_oready, r_ov;
   logic [15:0] r_od;

   logic [2:0]  t_valid, t_iready;
   logic [47:0] t_data;
   logic [1:0]  t_sel, t_oid;
   logic        t_oready, t_ov;
   logic [15:0] t_od;

   arb_mux_nto1 #(.WIDTH(16), .N(4), .RR_MODE(MODE_FIXED)) u_fix (
      .clk(clk), .rst_n(rst_n), .in_valid(f_valid), .in_data(f_data),
      .in_ready(f_iready), .sel(f_sel), .out_valid(f_ov), .out_data(f_od),
      .out_id(f_oid), .out_ready(f_oready));

   arb_mux_nto1 #(.WIDTH(16), .N(4), .RR_MODE(MODE_RR)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(r_valid), .in_data(r_data),
      .in_ready(r_iready), .sel(r_sel), .out_valid(r_ov), .out_data(r_od),
      .out_id(r_oid), .out_ready(r_oready));

   arb_mux_nto1 #(.WIDTH(16), .N(3), .RR_MODE(MODE_FIXED)) u_n3 (
      .clk(clk), .rst_n(rst_n), .in_valid(t_valid), .in_data(t_data),
      .in_ready(t_iready), .sel(t_sel), .out_valid(t_ov), .out_data(t_od),
      .out_id(t_oid), .out_ready(t_oready));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  valid;
      logic [1:0]  sel;
      logic        oready;
      logic [3:0]  exp_ir;
      logic        exp_ov;
      logic [15:0] exp_d;
      logic [1:0]  exp_id;
   } vec_t;

   vec_t fv[9];

   task automatic rr_step(input logic [3:0] v, input int exp_id, input string tag);
      @(negedge clk);
      r_valid  = v;
      r_oready = 1'b1;
      #1 chk($sformatf("%s_iready", tag), 32'(r_iready), 32'(1) << exp_id);
      @(posedge clk);
      #1;
      chk($sformatf("%s_id", tag), 32'(r_oid), 32'(exp_id));
      chk($sformatf("%s_data", tag), 32'(r_od), 32'(16'h10) + 32'(exp_id));
      chk($sformatf("%s_ov", tag), 32'(r_ov), 32'(1));
   endtask

   int fair_ids[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int skip_ids[4] = '{1, 3, 1, 3};

   initial begin
      // in_data = {4,3,2,1}: channel i carries i+1
      fv[0] = '{4'b1111, 2'd0, 1'b1, 4'b0001, 1'b1, 16'd1, 2'd0};
      fv[1] = '{4'b1111, 2'd1, 1'b1, 4'b0010, 1'b1, 16'd2, 2'd1};
      fv[2] = '{4'b1111, 2'd2, 1'b1, 4'b0100, 1'b1, 16'd3, 2'd2};
      fv[3] = '{4'b1111, 2'd3, 1'b1, 4'b1000, 1'b1, 16'd4, 2'd3};
      fv[4] = '{4'b0000, 2'd0, 1'b1, 4'b0000, 1'b0, 16'd4, 2'd3};
      fv[5] = '{4'b1111, 2'd2, 1'b0, 4'b0100, 1'b1, 16'd3, 2'd2};
      fv[6] = '{4'b1111, 2'd1, 1'b0, 4'b0000, 1'b1, 16'd3, 2'd2};
      fv[7] = '{4'b1111, 2'd1, 1'b1, 4'b0010, 1'b1, 16'd2, 2'd1};
      fv[8] = '{4'b0001, 2'd1, 1'b1, 4'b0000, 1'b0, 16'd2, 2'd1};

      f_valid = 4'b1111; f_sel = 2'd0; f_oready = 1'b1;
      f_data  = {16'd4, 16'd3, 16'd2, 16'd1};
      r_valid = 4'b0000; r_sel = 2'd0; r_oready = 1'b1;
      r_data  = {16'h13, 16'h12, 16'h11, 16'h10};
      t_valid = 3'b000; t_sel = 2'd0; t_oready = 1'b1;
      t_data  = {16'h302, 16'h301, 16'h300};

      // Reset state while rst_n held low, across a clock edge
      #7;
      chk("rst_ov", 32'(f_ov), 32'(0));
      chk("rst_data", 32'(f_od), 32'(0));
      chk("rst_id", 32'(f_oid), 32'(0));
      chk("rst_iready", 32'(f_iready), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Fixed-select vectors
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         f_valid  = fv[i].valid;
         f_sel    = fv[i].sel;
         f_oready = fv[i].oready;
         #1 chk($sformatf("fix%0d_iready", i), 32'(f_iready), 32'(fv[i].exp_ir));
         @(posedge clk);
         #1;
         chk($sformatf("fix%0d_ov", i), 32'(f_ov), 32'(fv[i].exp_ov));
         chk($sformatf("fix%0d_data", i), 32'(f_od), 32'(fv[i].exp_d));
         chk($sformatf("fix%0d_id", i), 32'(f_oid), 32'(fv[i].exp_id));
      end

      // Backpressure: hold A5A5 for 5 stalled cycles, then drain+reload
      @(negedge clk);
      f_data[15:0] = 16'hA5A5;
      f_valid = 4'b0001; f_sel = 2'd0; f_oready = 1'b1;
      @(posedge clk);
      #1 chk("bp_load", 32'(f_od), 32'(16'hA5A5));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         f_oready = 1'b0;
         f_data[15:0] = 16'h1234;
         #1 chk($sformatf("bp%0d_iready", c), 32'(f_iready), 32'(0));
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_data", c), 32'(f_od), 32'(16'hA5A5));
         chk($sformatf("bp%0d_ov", c), 32'(f_ov), 32'(1));
      end
      @(negedge clk);
      f_oready = 1'b1;
      #1 chk("bp_rel_iready", 32'(f_iready), 32'(4'b0001));
      @(posedge clk);
      #1;
      chk("bp_rel_data", 32'(f_od), 32'(16'h1234));
      chk("bp_rel_ov", 32'(f_ov), 32'(1));

      // Round-robin fairness, then skip over idle channels
      for (int i = 0; i < 8; i++) rr_step(4'b1111, fair_ids[i], $sformatf("rrfair%0d", i));
      for (int i = 0; i < 4; i++) rr_step(4'b1010, skip_ids[i], $sformatf("rrskip%0d", i));
      rr_step(4'b0001, 0, "rrskip_ch0");

      // N=3: out-of-range select gives no grant, sel=2 loads channel 2
      @(negedge clk);
      t_valid = 3'b111; t_sel = 2'd3;
      #1 chk("n3_sel3_iready", 32'(t_iready), 32'(0));
      @(posedge clk);
      #1 chk("n3_sel3_ov", 32'(t_ov), 32'(0));
      @(negedge clk);
      t_sel = 2'd2;
      #1 chk("n3_sel2_iready", 32'(t_iready), 32'(3'b100));
      @(posedge clk);
      #1;
      chk("n3_sel2_data", 32'(t_od), 32'(16'h302));
      chk("n3_sel2_id", 32'(t_oid), 32'(2));
      chk("n3_sel2_ov", 32'(t_ov), 32'(1));

      // Async reset between edges while output is stalled
      @(negedge clk);
      f_oready = 1'b0; r_oready = 1'b0; r_valid = 4'b0000;
      @(posedge clk);
      #1;
      chk("pre_rst_f_ov", 32'(f_ov), 32'(1));
      chk("pre_rst_r_ov", 32'(r_ov), 32'(1));
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_f_ov", 32'(f_ov), 32'(0));
      chk("mid_rst_f_data", 32'(f_od), 32'(0));
      chk("mid_rst_f_id", 32'(f_oid), 32'(0));
      chk("mid_rst_r_ov", 32'(r_ov), 32'(0));
      chk("mid_rst_f_iready", 32'(f_iready), 32'(0));
      #1 rst_n = 1'b1;
      rr_step(4'b1111, 0, "rr_after_rst");
      rr_step(4'b1111, 1, "rr_after_rst2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
